// File: rtl/dp_seq_pkg.sv
// dp_seq_pkg: shared opcodes, register indices and state encoding for the
// Fibonacci datapath sequencer.
package dp_seq_pkg;
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_PASSA = 3'b010;
    localparam logic [2:0] OP_DEC   = 3'b011;
    localparam logic [2:0] OP_CLR   = 3'b100;
    localparam logic [2:0] OP_INC   = 3'b101;

    localparam int R0 = 0;
    localparam int R1 = 1;
    localparam int R2 = 2;
    localparam int R3 = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_LDN, S_CLR0, S_INC1, S_TEST,
        S_ADD, S_MV0, S_MV1, S_DEC, S_FIN
    } state_t;
endpackage

// File: rtl/dp_seq_decode.sv
// dp_seq_decode: pure state-to-control-word decoder for dp_sequencer.
module dp_seq_decode import dp_seq_pkg::*; #(
    parameter int OPW = 3,
    parameter int AW  = 2
) (
    input  state_t           state,
    output logic [OPW-1:0]   alu_opcode,
    output logic [AW-1:0]    rd_addr1,
    output logic [AW-1:0]    rd_addr2,
    output logic [AW-1:0]    wrt_addr,
    output logic             wrt_en,
    output logic             load_data,
    output logic             busy,
    output logic             done
);
    always_comb begin
        alu_opcode = '0;
        rd_addr1   = '0;
        rd_addr2   = '0;
        wrt_addr   = '0;
        wrt_en     = 1'b0;
        load_data  = 1'b0;
        case (state)
            S_LDN: begin
                load_data = 1'b1;
                wrt_en    = 1'b1;
                wrt_addr  = AW'(R3);
            end
            S_CLR0: begin
                alu_opcode = OPW'(OP_CLR);
                wrt_en     = 1'b1;
                wrt_addr   = AW'(R0);
            end
            S_INC1: begin
                alu_opcode = OPW'(OP_INC);
                rd_addr1   = AW'(R0);
                wrt_en     = 1'b1;
                wrt_addr   = AW'(R1);
            end
            S_TEST: begin
                alu_opcode = OPW'(OP_PASSA);
                rd_addr1   = AW'(R3);
            end
            S_ADD: begin
                alu_opcode = OPW'(OP_ADD);
                rd_addr1   = AW'(R0);
                rd_addr2   = AW'(R1);
                wrt_en     = 1'b1;
                wrt_addr   = AW'(R2);
            end
            S_MV0: begin
                alu_opcode = OPW'(OP_PASSA);
                rd_addr1   = AW'(R1);
                wrt_en     = 1'b1;
                wrt_addr   = AW'(R0);
            end
            S_MV1: begin
                alu_opcode = OPW'(OP_PASSA);
                rd_addr1   = AW'(R2);
                wrt_en     = 1'b1;
                wrt_addr   = AW'(R1);
            end
            S_DEC: begin
                alu_opcode = OPW'(OP_DEC);
                rd_addr1   = AW'(R3);
                wrt_en     = 1'b1;
                wrt_addr   = AW'(R3);
            end
            default: ;
        endcase
    end

    assign busy = state != S_IDLE;
    assign done = state == S_FIN;
endmodule

// File: rtl/dp_sequencer.sv
// dp_sequencer: control FSM computing fib(N) on an external ALU/register file.
// Optional cancel input enabled by defining DP_SEQ_ABORT_EN.
module dp_sequencer import dp_seq_pkg::*; #(
    parameter int OPW = 3,
    parameter int AW  = 2,
    parameter int CW  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ZERO_FLAG,
`ifdef DP_SEQ_ABORT_EN
    input  logic             ABORT,
`endif
    output logic [OPW-1:0]   alu_opcode,
    output logic [AW-1:0]    rd_addr1,
    output logic [AW-1:0]    rd_addr2,
    output logic [AW-1:0]    wrt_addr,
    output logic             wrt_en,
    output logic             load_data,
    output logic             BUSY,
    output logic             DONE,
    output logic [CW-1:0]    iter_cnt
);
    state_t state, next;
    logic   dec_wrt_en;
    logic   abort;

`ifdef DP_SEQ_ABORT_EN
    assign abort  = ABORT && state != S_IDLE;
    assign wrt_en = dec_wrt_en && !ABORT;
`else
    assign abort  = 1'b0;
    assign wrt_en = dec_wrt_en;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE: next = START ? S_LDN : S_IDLE;
            S_LDN:  next = S_CLR0;
            S_CLR0: next = S_INC1;
            S_INC1: next = S_TEST;
            S_TEST: next = ZERO_FLAG ? S_FIN : S_ADD;
            S_ADD:  next = S_MV0;
            S_MV0:  next = S_MV1;
            S_MV1:  next = S_DEC;
            S_DEC:  next = ZERO_FLAG ? S_FIN : S_ADD;
            default: next = S_IDLE;
        endcase
        if (abort)
            next = S_IDLE;
    end

    // Only a non-aborted DEC exit counts as a completed iteration.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            iter_cnt <= '0;
        else if (next == S_LDN)
            iter_cnt <= '0;
        else if (state == S_DEC && next != S_IDLE)
            iter_cnt <= iter_cnt + CW'(1);
    end

    dp_seq_decode #(.OPW(OPW), .AW(AW)) u_decode (
        .state      (state),
        .alu_opcode (alu_opcode),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .wrt_addr   (wrt_addr),
        .wrt_en     (dec_wrt_en),
        .load_data  (load_data),
        .busy       (BUSY),
        .done       (DONE)
    );
endmodule

// File: tb/tb_dp_sequencer.sv
// tb_dp_sequencer: directed self-checking bench with a small ALU/register-file
// model; the abort scenario runs only when DP_SEQ_ABORT_EN is defined.
module tb_dp_sequencer;
    localparam int S_IDLE = 0, S_LDN = 1, S_CLR0 = 2, S_INC1 = 3, S_TEST = 4;
    localparam int S_ADD = 5, S_MV0 = 6, S_MV1 = 7, S_DEC = 8, S_FIN = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       zero_flag;
    logic       force_zf = 1'b0;
`ifdef DP_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic [2:0] alu_opcode;
    logic [1:0] rd_addr1, rd_addr2, wrt_addr;
    logic       wrt_en, load_data, busy, done;
    logic [7:0] iter_cnt;
    logic [7:0] n_bus = 8'd0;
    logic [7:0] rf [4];
    logic [7:0] alu_a, alu_b, alu_y;
    logic [12:0] obs;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dp_sequencer dut (
        .CLK        (clk),
        .RST        (rst),
        .START      (start),
        .ZERO_FLAG  (zero_flag),
`ifdef DP_SEQ_ABORT_EN
        .ABORT      (abort),
`endif
        .alu_opcode (alu_opcode),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .wrt_addr   (wrt_addr),
        .wrt_en     (wrt_en),
        .load_data  (load_data),
        .BUSY       (busy),
        .DONE       (done),
        .iter_cnt   (iter_cnt)
    );

    assign alu_a = rf[rd_addr1];
    assign alu_b = rf[rd_addr2];
    always_comb begin
        alu_y = 8'd0;
        case (alu_opcode)
            3'b000: alu_y = alu_a + alu_b;
            3'b001: alu_y = alu_a - alu_b;
            3'b010: alu_y = alu_a;
            3'b011: alu_y = alu_a - 8'd1;
            3'b100: alu_y = 8'd0;
            3'b101: alu_y = alu_a + 8'd1;
            default: alu_y = 8'd0;
        endcase
    end
    assign zero_flag = force_zf | (alu_y == 8'd0);
    always @(posedge clk) if (wrt_en) rf[wrt_addr] <= load_data ? n_bus : alu_y;

    assign obs = {alu_opcode, rd_addr1, rd_addr2, wrt_addr, wrt_en, load_data, busy, done};

    // {op, rd1, rd2, wa, wen, ld, busy, done} expected for each state
    function automatic logic [12:0] cw(int s);
        case (s)
            S_LDN:  return {3'b000, 2'd0, 2'd0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0};
            S_CLR0: return {3'b100, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
            S_INC1: return {3'b101, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0};
            S_TEST: return {3'b010, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
            S_ADD:  return {3'b000, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0};
            S_MV0:  return {3'b010, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
            S_MV1:  return {3'b010, 2'd2, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0};
            S_DEC:  return {3'b011, 2'd3, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0};
            S_FIN:  return {3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
            default: return 13'd0;
        endcase
    endfunction

    // expected state in cycle k (1 = LDN) of a run with count n
    function automatic int seq_at(int n, int k);
        if (k == 1) return S_LDN;
        if (k == 2) return S_CLR0;
        if (k == 3) return S_INC1;
        if (k == 4) return S_TEST;
        if (k == 5 + 4 * n) return S_FIN;
        case ((k - 5) % 4)
            0: return S_ADD;
            1: return S_MV0;
            2: return S_MV1;
            default: return S_DEC;
        endcase
    endfunction

    task automatic test_reset();
        #1;
        tests++;
        if (obs !== 13'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want %b", obs, 13'd0);
        end
        tests++;
        if (iter_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_iter_cnt: got %0d want 0", iter_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (obs !== cw(S_IDLE)) begin
            fails++;
            $display("FAIL idle_after_reset: got %b want %b", obs, cw(S_IDLE));
        end
    endtask

    task automatic test_n0();
        n_bus = 8'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tests++;
            if (obs !== cw(seq_at(0, k))) begin
                fails++;
                $display("FAIL n0_cycle%0d: got %b want %b", k, obs, cw(seq_at(0, k)));
            end
            @(negedge clk);
        end
        tests++;
        if (obs !== cw(S_IDLE)) begin
            fails++;
            $display("FAIL n0_idle: got %b want %b", obs, cw(S_IDLE));
        end
        tests++;
        if (iter_cnt !== 8'd0 || rf[0] !== 8'd0) begin
            fails++;
            $display("FAIL n0_result: iter_cnt %0d r0 %0d want 0 0", iter_cnt, rf[0]);
        end
    endtask

    task automatic test_n10();
        int dones = 0;
        int done_cyc = 0;
        n_bus = 8'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            if (done) begin
                dones++;
                done_cyc = k;
            end
            tests++;
            if (obs !== cw(k <= 45 ? seq_at(10, k) : S_IDLE)) begin
                fails++;
                $display("FAIL n10_cycle%0d: got %b want %b", k, obs,
                         cw(k <= 45 ? seq_at(10, k) : S_IDLE));
            end
            @(negedge clk);
        end
        tests++;
        if (dones !== 1 || done_cyc !== 45) begin
            fails++;
            $display("FAIL n10_done: %0d pulses at cycle %0d want 1 at 45", dones, done_cyc);
        end
        tests++;
        if (iter_cnt !== 8'd10) begin
            fails++;
            $display("FAIL n10_iter_cnt: got %0d want 10", iter_cnt);
        end
        tests++;
        if (rf[0] !== 8'd55) begin
            fails++;
            $display("FAIL n10_r0: got %0d want 55", rf[0]);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        n_bus = 8'd1;
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 30; k++) begin
            if (done) dones++;
            tests++;
            if (obs !== cw(((k - 1) % 10) + 1 <= 9 ? seq_at(1, ((k - 1) % 10) + 1) : S_IDLE)) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got %b want %b", k, obs,
                         cw(((k - 1) % 10) + 1 <= 9 ? seq_at(1, ((k - 1) % 10) + 1) : S_IDLE));
            end
            if (k == 30) start = 1'b0;
            @(negedge clk);
        end
        tests++;
        if (obs !== cw(S_IDLE) || dones !== 3) begin
            fails++;
            $display("FAIL b2b_end: got %b dones %0d want %b dones 3", obs, dones, cw(S_IDLE));
        end
        tests++;
        if (iter_cnt !== 8'd1 || rf[0] !== 8'd1) begin
            fails++;
            $display("FAIL b2b_result: iter_cnt %0d r0 %0d want 1 1", iter_cnt, rf[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        n_bus = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 10; k++) @(negedge clk);
        tests++;
        if (obs !== cw(S_MV0) || iter_cnt !== 8'd1) begin
            fails++;
            $display("FAIL rst_pre: got %b cnt %0d want %b cnt 1", obs, iter_cnt, cw(S_MV0));
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (obs !== 13'd0 || iter_cnt !== 8'd0) begin
            fails++;
            $display("FAIL rst_async: got %b cnt %0d want 0 cnt 0", obs, iter_cnt);
        end
        @(negedge clk);
        tests++;
        if (obs !== 13'd0) begin
            fails++;
            $display("FAIL rst_held: got %b want 0", obs);
        end
        rst = 1'b0;
        n_bus = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tests++;
            if (obs !== cw(seq_at(2, k))) begin
                fails++;
                $display("FAIL rst_rerun_cycle%0d: got %b want %b", k, obs, cw(seq_at(2, k)));
            end
            @(negedge clk);
        end
        tests++;
        if (rf[0] !== 8'd1 || iter_cnt !== 8'd2) begin
            fails++;
            $display("FAIL rst_rerun_result: r0 %0d cnt %0d want 1 2", rf[0], iter_cnt);
        end
    endtask

    task automatic test_zero_flag_ignored();
        n_bus = 8'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            force_zf = seq_at(3, k) != S_TEST && seq_at(3, k) != S_DEC;
            tests++;
            if (obs !== cw(seq_at(3, k))) begin
                fails++;
                $display("FAIL zf_cycle%0d: got %b want %b", k, obs, cw(seq_at(3, k)));
            end
            @(negedge clk);
        end
        force_zf = 1'b0;
        tests++;
        if (rf[0] !== 8'd2 || iter_cnt !== 8'd3) begin
            fails++;
            $display("FAIL zf_result: r0 %0d cnt %0d want 2 3", rf[0], iter_cnt);
        end
    endtask

`ifdef DP_SEQ_ABORT_EN
    task automatic test_abort();
        n_bus = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 13; k++) @(negedge clk);
        abort = 1'b1;
        #1;
        tests++;
        if (obs !== (cw(S_ADD) & ~13'b0000000001000)) begin
            fails++;
            $display("FAIL abort_cycle: got %b want %b", obs, cw(S_ADD) & ~13'b0000000001000);
        end
        @(negedge clk);
        tests++;
        if (obs !== cw(S_IDLE) || iter_cnt !== 8'd2) begin
            fails++;
            $display("FAIL abort_idle: got %b cnt %0d want %b cnt 2", obs, iter_cnt, cw(S_IDLE));
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (obs !== (cw(S_LDN) & ~13'b0000000001000)) begin
            fails++;
            $display("FAIL abort_in_idle: got %b want %b", obs, cw(S_LDN) & ~13'b0000000001000);
        end
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (obs !== cw(S_IDLE) || iter_cnt !== 8'd0) begin
            fails++;
            $display("FAIL abort_ldn: got %b cnt %0d want %b cnt 0", obs, iter_cnt, cw(S_IDLE));
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) rf[i] = 8'd0;
        test_reset();
        test_n0();
        test_n10();
        test_back_to_back();
        test_reset_mid_run();
        test_zero_flag_ignored();
`ifdef DP_SEQ_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1);
    end
endmodule
